// File: rtl/ps2_key_tracker_if.sv
// Byte-stream and key-state signal bundle between the PS/2 receiver side and the key tracker.
// The master drives scancodes and flush; the slave reports the held keys, active note and volume events.
interface ps2_key_tracker_if #(
    parameter int N_KEYS = 8,
    parameter int IDX_W  = 3
);
    logic [7:0]        ps2_data_i;
    logic              ps2_data_val_i;
    logic              flush_i;
    logic [N_KEYS-1:0] keys_held_o;
    logic              gate_o;
    logic [IDX_W-1:0]  num_o;
    logic              note_on_o;
    logic              vol_cntrl_o;
    logic              vol_cntrl_val_o;
    logic              err_o;

    modport master (
        output ps2_data_i, ps2_data_val_i, flush_i,
        input  keys_held_o, gate_o, num_o, note_on_o, vol_cntrl_o, vol_cntrl_val_o, err_o
    );

    modport slave (
        input  ps2_data_i, ps2_data_val_i, flush_i,
        output keys_held_o, gate_o, num_o, note_on_o, vol_cntrl_o, vol_cntrl_val_o, err_o
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scancode parser with a held-key bitmap, priority-based active note selection
// and volume up/down events from the extended media keys.
module ps2_key_tracker #(
    parameter int                  N_KEYS         = 8,
    parameter logic [N_KEYS*8-1:0] KEY_MAP        = {8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16},
    parameter int                  PRIORITY       = 0,
    parameter int                  VOL_REPEAT     = 0,
    parameter int                  TIMEOUT_CYCLES = 1_000_000,
    parameter int                  IDX_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ps2_key_tracker_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tcnt_q;
    logic [N_KEYS-1:0] keys_q, keys_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              note_on_q, vol_dir_q, vol_val_q, err_q;
    logic              vol_up_q, vol_dn_q;

    logic [7:0]        data;
    logic              is_ctrl, byte_acc, timeout_hit;
    logic              ev_make, ev_break, ev_ext;
    logic              key_hit;
    logic [IDX_W-1:0]  key_idx;
    logic              vol_ev, vol_dir_d, vol_up_d, vol_dn_d;
    logic [IDX_W-1:0]  num_cur, num_d;
    logic              note_on_d;

    assign data        = bus.ps2_data_i;
    assign is_ctrl     = data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF};
    assign byte_acc    = bus.ps2_data_val_i && !is_ctrl;
    // Control bytes freeze the prefix counter, so any strobe holds off a timeout that cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && !bus.ps2_data_val_i &&
                         (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    function automatic logic [IDX_W-1:0] lowest(input logic [N_KEYS-1:0] k);
        lowest = '0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (k[i]) lowest = IDX_W'(i);
    endfunction

    function automatic logic [IDX_W-1:0] highest(input logic [N_KEYS-1:0] k);
        highest = '0;
        for (int i = 0; i < N_KEYS; i++)
            if (k[i]) highest = IDX_W'(i);
    endfunction

    function automatic logic [IDX_W-1:0] pick(input logic [N_KEYS-1:0] k, input logic [IDX_W-1:0] last);
        if (k == '0)            pick = '0;
        else if (PRIORITY == 1) pick = lowest(k);
        else if (PRIORITY == 2) pick = highest(k);
        else                    pick = last;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else if (byte_acc) begin
            unique case (state_q)
                IDLE:    if (data == 8'hE0) state_d = EXT;
                         else if (data == 8'hF0) state_d = BRK;
                EXT:     if (data == 8'hF0) state_d = EXT_BRK;
                         else if (data != 8'hE0) state_d = IDLE;
                BRK:     if (data != 8'hF0) state_d = IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (byte_acc && !bus.flush_i) begin
            unique case (state_q)
                IDLE:    ev_make = (data != 8'hE0) && (data != 8'hF0);
                EXT:     begin
                             ev_make = (data != 8'hE0) && (data != 8'hF0);
                             ev_ext  = 1'b1;
                         end
                BRK:     ev_break = (data != 8'hF0);
                EXT_BRK: begin
                             ev_break = 1'b1;
                             ev_ext   = 1'b1;
                         end
                default: ;
            endcase
        end
    end

    // Scan downwards so the lowest matching table entry wins.
    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (KEY_MAP[8*i +: 8] == data) begin
                key_hit = 1'b1;
                key_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        keys_d = keys_q;
        last_d = last_q;
        if (bus.flush_i) begin
            keys_d = '0;
        end else if (key_hit && !ev_ext) begin
            if (ev_make && !keys_q[key_idx]) begin
                keys_d[key_idx] = 1'b1;
                last_d          = key_idx;
            end
            if (ev_break) keys_d[key_idx] = 1'b0;
        end
        // Releasing the last-pressed key hands the note to the lowest key still down.
        if (keys_d != '0 && !keys_d[last_d]) last_d = lowest(keys_d);
        num_cur   = pick(keys_q, last_q);
        num_d     = pick(keys_d, last_d);
        note_on_d = (keys_d != '0) && ((keys_q == '0) || (num_d != num_cur));
    end

    always_comb begin
        vol_ev    = 1'b0;
        vol_dir_d = vol_dir_q;
        vol_up_d  = vol_up_q;
        vol_dn_d  = vol_dn_q;
        if (bus.flush_i) begin
            vol_up_d = 1'b0;
            vol_dn_d = 1'b0;
        end else if (ev_ext && data == 8'h32) begin
            if (ev_make) begin
                vol_ev    = !vol_up_q || (VOL_REPEAT != 0);
                vol_up_d  = 1'b1;
                if (vol_ev) vol_dir_d = 1'b1;
            end else if (ev_break) begin
                vol_up_d = 1'b0;
            end
        end else if (ev_ext && data == 8'h21) begin
            if (ev_make) begin
                vol_ev    = !vol_dn_q || (VOL_REPEAT != 0);
                vol_dn_d  = 1'b1;
                if (vol_ev) vol_dir_d = 1'b0;
            end else if (ev_break) begin
                vol_dn_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt_q    <= '0;
            keys_q    <= '0;
            last_q    <= '0;
            note_on_q <= 1'b0;
            vol_dir_q <= 1'b0;
            vol_val_q <= 1'b0;
            vol_up_q  <= 1'b0;
            vol_dn_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (bus.flush_i || byte_acc || timeout_hit) tcnt_q <= '0;
            else if (state_q != IDLE && !bus.ps2_data_val_i) tcnt_q <= tcnt_q + CNT_W'(1);
            keys_q    <= keys_d;
            last_q    <= last_d;
            note_on_q <= note_on_d;
            vol_dir_q <= vol_dir_d;
            vol_val_q <= vol_ev;
            vol_up_q  <= vol_up_d;
            vol_dn_q  <= vol_dn_d;
            err_q     <= timeout_hit && !bus.flush_i;
        end
    end

    assign bus.keys_held_o     = keys_q;
    assign bus.gate_o          = |keys_q;
    assign bus.num_o           = num_cur;
    assign bus.note_on_o       = note_on_q;
    assign bus.vol_cntrl_o     = vol_dir_q;
    assign bus.vol_cntrl_val_o = vol_val_q;
    assign bus.err_o           = err_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: three instances (last-pressed, lowest, highest priority) share one
// scancode stream and are checked against directed expectations and a behavioural model.
module tb_ps2_key_tracker;
    localparam logic [63:0] MAP = {8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16};
    localparam int TMO = 100;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    ps2_key_tracker_if #(.N_KEYS(8), .IDX_W(3)) if_a ();
    ps2_key_tracker_if #(.N_KEYS(8), .IDX_W(3)) if_b ();
    ps2_key_tracker_if #(.N_KEYS(8), .IDX_W(3)) if_c ();

    ps2_key_tracker #(.N_KEYS(8), .KEY_MAP(MAP), .PRIORITY(0), .VOL_REPEAT(0), .TIMEOUT_CYCLES(TMO))
        dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(if_a));
    ps2_key_tracker #(.N_KEYS(8), .KEY_MAP(MAP), .PRIORITY(1), .VOL_REPEAT(1), .TIMEOUT_CYCLES(TMO))
        dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(if_b));
    ps2_key_tracker #(.N_KEYS(8), .KEY_MAP(MAP), .PRIORITY(2), .VOL_REPEAT(0), .TIMEOUT_CYCLES(TMO))
        dut_c (.clk_i(clk_i), .rst_i(rst_i), .bus(if_c));

    int checks = 0;
    int passes = 0;

    // Reference model: prefix flags, held set, last pressed note and per-instance volume view.
    int mode[3] = '{0, 1, 2};
    int vrep[3] = '{0, 1, 0};
    bit [7:0] m_held;
    int       m_last;
    bit       m_ext, m_brk, m_vup, m_vdn, m_err;
    int       m_cnt;
    bit       m_vdir[3], m_vval[3], m_non[3];

    function automatic bit is_ctrl(input logic [7:0] d);
        return d inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF};
    endfunction

    function automatic int map_idx(input logic [7:0] d);
        logic [63:0] m;
        m = MAP;
        for (int i = 0; i < 8; i++)
            if (m[8*i +: 8] == d) return i;
        return -1;
    endfunction

    function automatic int lowest_held(input bit [7:0] h);
        for (int i = 0; i < 8; i++) if (h[i]) return i;
        return 0;
    endfunction

    function automatic int exp_num(input int md, input bit [7:0] h, input int last);
        if (h == 0) return 0;
        if (md == 1) return lowest_held(h);
        if (md == 2) begin
            for (int i = 7; i >= 0; i--) if (h[i]) return i;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_held = 0; m_last = 0; m_ext = 0; m_brk = 0; m_vup = 0; m_vdn = 0; m_err = 0; m_cnt = 0;
        for (int k = 0; k < 3; k++) begin m_vdir[k] = 0; m_vval[k] = 0; m_non[k] = 0; end
    endtask

    task automatic model_make(input logic [7:0] d, input bit e);
        int idx;
        if (!e) begin
            idx = map_idx(d);
            if (idx >= 0 && !m_held[idx]) begin m_held[idx] = 1; m_last = idx; end
        end else if (d == 8'h32 || d == 8'h21) begin
            for (int k = 0; k < 3; k++) begin
                m_vval[k] = ((d == 8'h32) ? !m_vup : !m_vdn) || (vrep[k] != 0);
                if (m_vval[k]) m_vdir[k] = (d == 8'h32);
            end
            if (d == 8'h32) m_vup = 1; else m_vdn = 1;
        end
    endtask

    task automatic model_break(input logic [7:0] d, input bit e);
        int idx;
        if (!e) begin
            idx = map_idx(d);
            if (idx >= 0) m_held[idx] = 0;
            if (m_held != 0 && !m_held[m_last]) m_last = lowest_held(m_held);
        end else if (d == 8'h32) m_vup = 0;
        else if (d == 8'h21) m_vdn = 0;
    endtask

    task automatic model_step(input logic [7:0] d, input bit v, input bit f);
        int old_num[3];
        bit old_gate;
        for (int k = 0; k < 3; k++) old_num[k] = exp_num(mode[k], m_held, m_last);
        old_gate = (m_held != 0);
        m_err = 0;
        for (int k = 0; k < 3; k++) m_vval[k] = 0;
        if (f) begin
            m_held = 0; m_vup = 0; m_vdn = 0; m_ext = 0; m_brk = 0; m_cnt = 0;
        end else if (v && is_ctrl(d)) begin
            m_cnt = m_cnt;
        end else if (v) begin
            m_cnt = 0;
            if (!m_ext && !m_brk) begin
                if (d == 8'hE0) m_ext = 1;
                else if (d == 8'hF0) m_brk = 1;
                else model_make(d, 0);
            end else if (m_ext && !m_brk) begin
                if (d == 8'hF0) m_brk = 1;
                else if (d != 8'hE0) begin model_make(d, 1); m_ext = 0; end
            end else if (!m_ext && m_brk) begin
                if (d != 8'hF0) begin model_break(d, 0); m_brk = 0; end
            end else begin
                model_break(d, 1); m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_cnt++;
            if (m_cnt == TMO) begin m_ext = 0; m_brk = 0; m_cnt = 0; m_err = 1; end
        end
        for (int k = 0; k < 3; k++)
            m_non[k] = (m_held != 0) && (!old_gate || exp_num(mode[k], m_held, m_last) != old_num[k]);
    endtask

    task automatic cycle(input logic [7:0] d, input bit v, input bit f);
        if_a.ps2_data_i = d; if_a.ps2_data_val_i = v; if_a.flush_i = f;
        if_b.ps2_data_i = d; if_b.ps2_data_val_i = v; if_b.flush_i = f;
        if_c.ps2_data_i = d; if_c.ps2_data_val_i = v; if_c.flush_i = f;
        @(posedge clk_i);
        #1;
        model_step(d, v, f);
    endtask

    task automatic send(input logic [7:0] d);
        cycle(d, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        if_a.ps2_data_val_i = 0; if_a.flush_i = 0; if_a.ps2_data_i = 0;
        if_b.ps2_data_val_i = 0; if_b.flush_i = 0; if_b.ps2_data_i = 0;
        if_c.ps2_data_val_i = 0; if_c.flush_i = 0; if_c.ps2_data_i = 0;
        model_reset();
        #12;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        if_a.ps2_data_val_i = 0; if_a.flush_i = 0; if_a.ps2_data_i = 0;
        if_b.ps2_data_val_i = 0; if_b.flush_i = 0; if_b.ps2_data_i = 0;
        if_c.ps2_data_val_i = 0; if_c.flush_i = 0; if_c.ps2_data_i = 0;
        model_reset();
        #12;
        checks++;
        if ({if_a.keys_held_o, if_b.keys_held_o, if_c.keys_held_o} !== 24'h0)
            $display("[TB] FAIL reset_keys: got %h want 0", {if_a.keys_held_o, if_b.keys_held_o, if_c.keys_held_o});
        else passes++;
        checks++;
        if ({if_a.gate_o, if_a.num_o, if_a.note_on_o, if_a.vol_cntrl_o, if_a.vol_cntrl_val_o, if_a.err_o} !== 8'h0)
            $display("[TB] FAIL reset_outs: got %b want 0",
                     {if_a.gate_o, if_a.num_o, if_a.note_on_o, if_a.vol_cntrl_o, if_a.vol_cntrl_val_o, if_a.err_o});
        else passes++;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_basic_press();
        send(8'h1E);
        checks++;
        if (if_a.keys_held_o !== 8'h02 || if_a.num_o !== 3'd1 || if_a.gate_o !== 1'b1 || if_a.note_on_o !== 1'b1)
            $display("[TB] FAIL press_1E: got keys %h num %0d gate %b on %b want 02 1 1 1",
                     if_a.keys_held_o, if_a.num_o, if_a.gate_o, if_a.note_on_o);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            send(8'h1E);
            checks++;
            if (if_a.keys_held_o !== 8'h02 || if_a.note_on_o !== 1'b0 || if_b.note_on_o !== 1'b0)
                $display("[TB] FAIL typematic: got keys %h on %b/%b want 02 0/0",
                         if_a.keys_held_o, if_a.note_on_o, if_b.note_on_o);
            else passes++;
        end
        send(8'hF0);
        send(8'h1E);
        checks++;
        if (if_a.keys_held_o !== 8'h00 || if_a.gate_o !== 1'b0 || if_a.num_o !== 3'd0)
            $display("[TB] FAIL release_1E: got keys %h gate %b num %0d want 00 0 0",
                     if_a.keys_held_o, if_a.gate_o, if_a.num_o);
        else passes++;
    endtask

    task automatic test_priority();
        int b_pulses;
        b_pulses = 0;
        send(8'h16);
        b_pulses += int'(if_b.note_on_o);
        send(8'h3E);
        b_pulses += int'(if_b.note_on_o);
        checks++;
        if (if_a.num_o !== 3'd7 || if_a.note_on_o !== 1'b1 || if_b.num_o !== 3'd0 || if_c.num_o !== 3'd7)
            $display("[TB] FAIL prio_two_held: got a %0d/%b b %0d c %0d want 7/1 0 7",
                     if_a.num_o, if_a.note_on_o, if_b.num_o, if_c.num_o);
        else passes++;
        send(8'hF0);
        b_pulses += int'(if_b.note_on_o);
        send(8'h3E);
        b_pulses += int'(if_b.note_on_o);
        checks++;
        if (if_a.num_o !== 3'd0 || if_a.note_on_o !== 1'b1 || if_c.note_on_o !== 1'b1 || if_a.gate_o !== 1'b1)
            $display("[TB] FAIL prio_fallback: got a %0d/%b c_on %b gate %b want 0/1 1 1",
                     if_a.num_o, if_a.note_on_o, if_c.note_on_o, if_a.gate_o);
        else passes++;
        checks++;
        if (b_pulses != 1) $display("[TB] FAIL prio_lowest_pulses: got %0d want 1", b_pulses);
        else passes++;
        send(8'hF0);
        send(8'h16);
    endtask

    task automatic test_volume();
        send(8'hE0); send(8'h32);
        checks++;
        if (if_a.vol_cntrl_o !== 1'b1 || if_a.vol_cntrl_val_o !== 1'b1)
            $display("[TB] FAIL vol_up: got %b/%b want 1/1", if_a.vol_cntrl_o, if_a.vol_cntrl_val_o);
        else passes++;
        send(8'hE0); send(8'h32);
        checks++;
        if (if_a.vol_cntrl_val_o !== 1'b0 || if_b.vol_cntrl_val_o !== 1'b1)
            $display("[TB] FAIL vol_repeat: got a %b b %b want 0 1", if_a.vol_cntrl_val_o, if_b.vol_cntrl_val_o);
        else passes++;
        send(8'hE0); send(8'hF0); send(8'h32);
        checks++;
        if (if_a.vol_cntrl_val_o !== 1'b0 || if_a.vol_cntrl_o !== 1'b1)
            $display("[TB] FAIL vol_up_break: got %b/%b want 1/0", if_a.vol_cntrl_o, if_a.vol_cntrl_val_o);
        else passes++;
        send(8'hE0); send(8'h21);
        checks++;
        if (if_a.vol_cntrl_o !== 1'b0 || if_a.vol_cntrl_val_o !== 1'b1)
            $display("[TB] FAIL vol_down: got %b/%b want 0/1", if_a.vol_cntrl_o, if_a.vol_cntrl_val_o);
        else passes++;
        send(8'hE0); send(8'hF0); send(8'h21);
        checks++;
        if (if_a.vol_cntrl_o !== 1'b0 || if_a.vol_cntrl_val_o !== 1'b0)
            $display("[TB] FAIL vol_down_break: got %b/%b want 0/0", if_a.vol_cntrl_o, if_a.vol_cntrl_val_o);
        else passes++;
    endtask

    task automatic test_ext_and_ctrl();
        send(8'hE0); send(8'h16);
        checks++;
        if (if_a.keys_held_o !== 8'h00 || if_a.note_on_o !== 1'b0)
            $display("[TB] FAIL ext_note_ignored: got %h/%b want 00/0", if_a.keys_held_o, if_a.note_on_o);
        else passes++;
        send(8'h16);
        send(8'hF0); send(8'hFA); send(8'hAA);
        checks++;
        if (if_a.keys_held_o !== 8'h01)
            $display("[TB] FAIL ctrl_hold: got %h want 01", if_a.keys_held_o);
        else passes++;
        send(8'h16);
        checks++;
        if (if_a.keys_held_o !== 8'h00 || if_a.gate_o !== 1'b0)
            $display("[TB] FAIL ctrl_break: got %h/%b want 00/0", if_a.keys_held_o, if_a.gate_o);
        else passes++;
    endtask

    task automatic test_timeout();
        int pulses, at;
        pulses = 0; at = -1;
        send(8'hE0);
        for (int i = 1; i <= TMO + 10; i++) begin
            cycle(8'h00, 1'b0, 1'b0);
            if (if_a.err_o === 1'b1) begin pulses++; at = i; end
        end
        checks++;
        if (pulses != 1 || at != TMO)
            $display("[TB] FAIL timeout_err: got %0d pulses at %0d want 1 at %0d", pulses, at, TMO);
        else passes++;
        send(8'h26);
        checks++;
        if (if_a.keys_held_o !== 8'h04 || if_a.note_on_o !== 1'b1 || if_a.err_o !== 1'b0)
            $display("[TB] FAIL timeout_idle: got %h/%b/%b want 04/1/0", if_a.keys_held_o, if_a.note_on_o, if_a.err_o);
        else passes++;
        send(8'hF0); send(8'h26);
    endtask

    task automatic test_flush();
        send(8'h16); send(8'h25); send(8'h36);
        send(8'hE0); send(8'h32);
        checks++;
        if (if_a.keys_held_o !== 8'h29 || if_a.vol_cntrl_o !== 1'b1)
            $display("[TB] FAIL flush_setup: got %h/%b want 29/1", if_a.keys_held_o, if_a.vol_cntrl_o);
        else passes++;
        cycle(8'h1E, 1'b1, 1'b1);
        checks++;
        if (if_a.keys_held_o !== 8'h00 || if_a.gate_o !== 1'b0 || if_a.note_on_o !== 1'b0 ||
            if_a.vol_cntrl_val_o !== 1'b0 || if_a.vol_cntrl_o !== 1'b1)
            $display("[TB] FAIL flush: got keys %h gate %b on %b val %b vol %b want 00 0 0 0 1",
                     if_a.keys_held_o, if_a.gate_o, if_a.note_on_o, if_a.vol_cntrl_val_o, if_a.vol_cntrl_o);
        else passes++;
        cycle(8'h00, 1'b0, 1'b0);
        send(8'hE0); send(8'h32);
        checks++;
        if (if_a.keys_held_o !== 8'h00 || if_a.vol_cntrl_val_o !== 1'b1)
            $display("[TB] FAIL flush_after: got %h/%b want 00/1", if_a.keys_held_o, if_a.vol_cntrl_val_o);
        else passes++;
    endtask

    task automatic test_async_reset();
        send(8'hE0);
        #2;
        rst_i = 1'b1;
        if_a.ps2_data_val_i = 0; if_b.ps2_data_val_i = 0; if_c.ps2_data_val_i = 0;
        model_reset();
        #1;
        checks++;
        if (if_a.vol_cntrl_o !== 1'b0 || if_a.keys_held_o !== 8'h00)
            $display("[TB] FAIL async_reset: got %b/%h want 0/00", if_a.vol_cntrl_o, if_a.keys_held_o);
        else passes++;
        @(negedge clk_i);
        rst_i = 1'b0;
        send(8'h32);
        checks++;
        if (if_a.vol_cntrl_val_o !== 1'b0 || if_b.vol_cntrl_val_o !== 1'b0 || if_a.vol_cntrl_o !== 1'b0)
            $display("[TB] FAIL reset_discards_prefix: got %b/%b/%b want 0/0/0",
                     if_a.vol_cntrl_val_o, if_b.vol_cntrl_val_o, if_a.vol_cntrl_o);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] pool[18] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'hF0,
                                 8'hE0, 8'hF0, 8'hE0, 8'h32, 8'h21, 8'hFA, 8'hAA, 8'h00, 8'h77};
        logic [7:0] d;
        bit v, f;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 17)];
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            cycle(d, v, f);
            for (int k = 0; k < 3; k++) begin
                logic [7:0] ak;
                logic [2:0] an;
                logic ag, ao, avd, avv, ae;
                case (k)
                    0: begin ak = if_a.keys_held_o; an = if_a.num_o; ag = if_a.gate_o; ao = if_a.note_on_o;
                             avd = if_a.vol_cntrl_o; avv = if_a.vol_cntrl_val_o; ae = if_a.err_o; end
                    1: begin ak = if_b.keys_held_o; an = if_b.num_o; ag = if_b.gate_o; ao = if_b.note_on_o;
                             avd = if_b.vol_cntrl_o; avv = if_b.vol_cntrl_val_o; ae = if_b.err_o; end
                    default: begin ak = if_c.keys_held_o; an = if_c.num_o; ag = if_c.gate_o; ao = if_c.note_on_o;
                             avd = if_c.vol_cntrl_o; avv = if_c.vol_cntrl_val_o; ae = if_c.err_o; end
                endcase
                checks++;
                if (ak !== m_held) $display("[TB] FAIL rand_keys dut%0d n%0d: got %h want %h", k, n, ak, m_held);
                else passes++;
                checks++;
                if (ag !== (m_held != 0)) $display("[TB] FAIL rand_gate dut%0d n%0d: got %b want %b", k, n, ag, m_held != 0);
                else passes++;
                checks++;
                if (int'(an) !== exp_num(mode[k], m_held, m_last))
                    $display("[TB] FAIL rand_num dut%0d n%0d: got %0d want %0d", k, n, an, exp_num(mode[k], m_held, m_last));
                else passes++;
                checks++;
                if (ao !== m_non[k]) $display("[TB] FAIL rand_note_on dut%0d n%0d: got %b want %b", k, n, ao, m_non[k]);
                else passes++;
                checks++;
                if (avd !== m_vdir[k] || avv !== m_vval[k])
                    $display("[TB] FAIL rand_vol dut%0d n%0d: got %b/%b want %b/%b", k, n, avd, avv, m_vdir[k], m_vval[k]);
                else passes++;
                checks++;
                if (ae !== m_err) $display("[TB] FAIL rand_err dut%0d n%0d: got %b want %b", k, n, ae, m_err);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_priority();
        test_volume();
        test_ext_and_ctrl();
        test_timeout();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
